// File: rtl/acqbuf_pkg.sv
// Shared definitions for the acquisition-buffer capture sequencer.
package acqbuf_pkg;

   localparam int unsigned ACQ_DW   = 32;
   localparam int unsigned ACQ_AW   = 10;
   localparam int unsigned ACQ_DLYW = 16;
   localparam int unsigned DEPTH    = 1 << ACQ_AW;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_DELAY,
      ST_CAPTURE,
      ST_DONE
   } acq_state_e;

endpackage

// File: rtl/acqbuf_ctrl_trig_edge.sv
// Registered rising-edge detector for the synchronous capture trigger.
module trig_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sig_i,
   output logic rise_o
);

   logic sig_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_i;
      end
   end

   assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/acqbuf_ctrl.sv
// Capture sequencer: arm, wait for trigger, skip a delay, write len samples
// into the acquisition BRAM, then hold done until acknowledged.
module acqbuf_ctrl
   import acqbuf_pkg::*;
#(
   parameter int unsigned DW   = ACQ_DW,
   parameter int unsigned AW   = ACQ_AW,
   parameter int unsigned DLYW = ACQ_DLYW
) (
   input  logic            dspclk,
   input  logic            rst,
   input  logic            arm,
   input  logic            abort,
   input  logic            ack,
   input  logic [AW:0]     len,
   input  logic [DLYW-1:0] dly,
   input  logic            trig,
   input  logic [DW-1:0]   din,
   input  logic            din_valid,
   output logic            bram_we,
   output logic [AW-1:0]   bram_addr,
   output logic [DW-1:0]   bram_din,
   output logic            busy,
   output logic            done,
   output logic [AW:0]     wcount,
   output logic            ovf
);

   localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};

   acq_state_e      state_q, state_d;
   logic [AW:0]     len_q, len_d;
   logic [DLYW-1:0] dly_q, dly_d;
   logic [AW:0]     wcount_q, wcount_d;
   logic            ovf_q, ovf_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   bdin_q, bdin_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            trig_rise;
   logic            load_cmd;
   logic [AW:0]     wnext;

   trig_edge u_trig_edge (
      .clk_i  (dspclk),
      .rst_i  (rst),
      .sig_i  (trig),
      .rise_o (trig_rise)
   );

   assign wnext = wcount_q + (AW+1)'(1);

   // ack in DONE frees the sequencer, so a simultaneous arm is taken the same cycle
   assign load_cmd = ~abort & arm &
                     ((state_q == ST_IDLE) | ((state_q == ST_DONE) & ack));

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      dly_d    = dly_q;
      wcount_d = wcount_q;
      ovf_d    = ovf_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      bdin_d   = bdin_q;

      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: ;
            ST_ARMED: begin
               if (trig_rise) begin
                  state_d = (dly_q == '0) ? ST_CAPTURE : ST_DELAY;
               end
            end
            ST_DELAY: begin
               if (din_valid) begin
                  dly_d = dly_q - DLYW'(1);
                  if (dly_q == DLYW'(1)) begin
                     state_d = ST_CAPTURE;
                  end
               end
            end
            ST_CAPTURE: begin
               if (len_q == '0) begin
                  state_d = ST_DONE;
               end else if (din_valid) begin
                  we_d     = 1'b1;
                  addr_d   = wcount_q[AW-1:0];
                  bdin_d   = din;
                  wcount_d = wnext;
                  if (wnext == len_q) begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (ack) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (load_cmd) begin
         state_d  = ST_ARMED;
         len_d    = (len > LEN_MAX) ? LEN_MAX : len;
         ovf_d    = (len > LEN_MAX);
         dly_d    = dly;
         wcount_d = '0;
      end

      busy_d = (state_d == ST_ARMED) | (state_d == ST_DELAY) | (state_d == ST_CAPTURE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge dspclk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         len_q    <= '0;
         dly_q    <= '0;
         wcount_q <= '0;
         ovf_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         bdin_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         dly_q    <= dly_d;
         wcount_q <= wcount_d;
         ovf_q    <= ovf_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         bdin_q   <= bdin_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bram_we   = we_q;
   assign bram_addr = addr_q;
   assign bram_din  = bdin_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign wcount    = wcount_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_acqbuf_ctrl.sv
// Self-checking bench for acqbuf_ctrl: captured BRAM contents and status are
// compared against a sample-list model of skip-dly-then-write-len behaviour.
module tb_acqbuf_ctrl;

   localparam int DEPTH_TB = 1024;

   logic        dspclk;
   logic        rst;
   logic        arm;
   logic        abort;
   logic        ack;
   logic [10:0] len;
   logic [15:0] dly;
   logic        trig;
   logic [31:0] din;
   logic        din_valid;
   logic        bram_we;
   logic [9:0]  bram_addr;
   logic [31:0] bram_din;
   logic        busy;
   logic        done;
   logic [10:0] wcount;
   logic        ovf;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [DEPTH_TB];
   int          nwrites = 0;

   acqbuf_ctrl #(.DW(32), .AW(10), .DLYW(16)) dut (
      .dspclk    (dspclk),
      .rst       (rst),
      .arm       (arm),
      .abort     (abort),
      .ack       (ack),
      .len       (len),
      .dly       (dly),
      .trig      (trig),
      .din       (din),
      .din_valid (din_valid),
      .bram_we   (bram_we),
      .bram_addr (bram_addr),
      .bram_din  (bram_din),
      .busy      (busy),
      .done      (done),
      .wcount    (wcount),
      .ovf       (ovf)
   );

   initial begin
      dspclk = 1'b0;
      forever #5 dspclk = ~dspclk;
   end

   // Bench-side BRAM: records every write presented on the port.
   always @(posedge dspclk) begin
      if (bram_we === 1'b1) begin
         mem[bram_addr] = bram_din;
         nwrites = nwrites + 1;
      end
   end

   task automatic tick();
      @(posedge dspclk);
      #1;
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ack_idle: done=%b busy=%b, required done=0 busy=0", done, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; arm = 1'b0; abort = 1'b0; ack = 1'b0; len = '0; dly = '0;
      trig = 1'b0; din = '0; din_valid = 1'b0;
      #23;
      checks++;
      if ({bram_we, bram_addr, bram_din, busy, done, wcount, ovf} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: we=%b addr=%0d din=%h busy=%b done=%b wcount=%0d ovf=%b, required all 0",
                  bram_we, bram_addr, bram_din, busy, done, wcount, ovf);
      end
      rst = 1'b0;
      tick();
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   // Model: of the valid samples presented after the trigger edge, the first dly
   // are skipped and the next min(len, DEPTH) land at addresses 0.. in order.
   task automatic test_capture(input int l, input int d, input int pct, input bit alt,
                               input bit rnd_data, input logic [31:0] base, input bit do_arm);
      logic [31:0] samp[$];
      logic [31:0] v;
      int n, fed, cyc, early_done, bad, first_bad;
      bit vld;
      n = (l > DEPTH_TB) ? DEPTH_TB : l;
      for (int i = 0; i < DEPTH_TB; i++) mem[i] = 'x;
      nwrites = 0;
      trig = 1'b0;
      if (do_arm) begin
         arm = 1'b1; len = 11'(l); dly = 16'(d);
         tick();
         arm = 1'b0;
      end else begin
         tick();
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || wcount !== '0) begin
         errors++;
         $display("FAIL armed_state: busy=%b done=%b wcount=%0d, required 1 0 0", busy, done, wcount);
      end
      tick();
      trig = 1'b1;
      tick();
      fed = 0; cyc = 0; early_done = 0;
      while (fed < d + n && cyc < 20000) begin
         vld = alt ? (cyc % 2 == 1) : ($urandom_range(0, 99) < pct);
         v = rnd_data ? $urandom : base + 32'(fed);
         din = v;
         din_valid = vld;
         if (done !== 1'b0) early_done++;
         tick();
         if (vld) begin
            samp.push_back(v);
            fed++;
         end
         cyc++;
      end
      din_valid = 1'b0;
      trig = 1'b0;
      checks++;
      if (cyc >= 20000) begin
         errors++;
         $display("FAIL feed_timeout: fed=%0d, required %0d", fed, d + n);
      end
      if (n == 0) begin
         for (int k = 0; k < 4 && done !== 1'b1; k++) tick();
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || early_done != 0) begin
         errors++;
         $display("FAIL done_timing: done=%b busy=%b early=%0d, required done=1 busy=0 early=0",
                  done, busy, early_done);
      end
      tick();
      checks++;
      if (nwrites != n || wcount !== 11'(n)) begin
         errors++;
         $display("FAIL write_count: writes=%0d wcount=%0d, required %0d", nwrites, wcount, n);
      end
      checks++;
      if (ovf !== (l > DEPTH_TB)) begin
         errors++;
         $display("FAIL ovf_flag: ovf=%b, required %b", ovf, l > DEPTH_TB);
      end
      bad = 0; first_bad = -1;
      for (int i = 0; i < n; i++) begin
         if (mem[i] !== samp[d + i]) begin
            bad++;
            if (first_bad < 0) first_bad = i;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bram_data: %0d bad words, first addr %0d got %h, required %h",
                  bad, first_bad, mem[first_bad], samp[d + first_bad]);
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_hold: done=%b, required 1", done);
      end
   endtask

   task automatic test_abort();
      nwrites = 0;
      arm = 1'b1; len = 11'd16; dly = 16'd0;
      tick();
      arm = 1'b0;
      trig = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         din = 32'hA000 + 32'(i); din_valid = 1'b1;
         tick();
      end
      abort = 1'b1; din = 32'hDEAD; din_valid = 1'b1;
      tick();
      abort = 1'b0; din_valid = 1'b0; trig = 1'b0;
      checks++;
      if (bram_we !== 1'b0 || wcount !== 11'd5 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_stop: we=%b wcount=%0d busy=%b done=%b, required 0 5 0 0",
                  bram_we, wcount, busy, done);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (done !== 1'b0 || nwrites != 5) begin
            errors++;
            $display("FAIL abort_quiet: done=%b writes=%0d, required 0 5", done, nwrites);
         end
      end
      test_capture(6, 1, 70, 1'b0, 1'b1, '0, 1'b1);
      do_ack();
   endtask

   task automatic test_ack_arm();
      test_capture(2, 0, 100, 1'b0, 1'b1, '0, 1'b1);
      arm = 1'b1; len = 11'd5; dly = 16'd0;
      tick();
      arm = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL arm_in_done: done=%b busy=%b, required 1 0", done, busy);
      end
      ack = 1'b1; arm = 1'b1; len = 11'd3; dly = 16'd0;
      tick();
      ack = 1'b0; arm = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || wcount !== '0) begin
         errors++;
         $display("FAIL ack_arm: busy=%b done=%b wcount=%0d, required 1 0 0", busy, done, wcount);
      end
      test_capture(3, 0, 80, 1'b0, 1'b1, '0, 1'b0);
      do_ack();
   endtask

   task automatic test_trig_held();
      trig = 1'b1;
      tick();
      nwrites = 0;
      arm = 1'b1; len = 11'd4; dly = 16'd0;
      tick();
      arm = 1'b0;
      for (int i = 0; i < 5; i++) begin
         din = $urandom; din_valid = 1'b1;
         tick();
      end
      din_valid = 1'b0;
      tick();
      checks++;
      if (nwrites != 0 || wcount !== '0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL trig_held: writes=%0d wcount=%0d busy=%b, required 0 0 1", nwrites, wcount, busy);
      end
      test_capture(4, 0, 100, 1'b0, 1'b1, '0, 1'b0);
      do_ack();
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         test_capture(int'($urandom_range(1, 40)), int'($urandom_range(0, 6)),
                      int'($urandom_range(30, 100)), 1'b0, 1'b1, '0, 1'b1);
         do_ack();
      end
   endtask

   task automatic test_rst_mid();
      arm = 1'b1; len = 11'd20; dly = 16'd0;
      tick();
      arm = 1'b0;
      trig = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         din = $urandom; din_valid = 1'b1;
         tick();
      end
      checks++;
      if (bram_we !== 1'b1 || wcount !== 11'd3) begin
         errors++;
         $display("FAIL pre_rst_capture: we=%b wcount=%0d, required 1 3", bram_we, wcount);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({bram_we, bram_addr, bram_din, busy, done, wcount, ovf} !== '0) begin
         errors++;
         $display("FAIL rst_mid: we=%b addr=%0d din=%h busy=%b done=%b wcount=%0d ovf=%b, required all 0",
                  bram_we, bram_addr, bram_din, busy, done, wcount, ovf);
      end
      #2;
      rst = 1'b0; din_valid = 1'b0; trig = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || bram_we !== 1'b0) begin
         errors++;
         $display("FAIL rst_release: busy=%b we=%b, required 0 0", busy, bram_we);
      end
   endtask

   initial begin
      test_reset();
      test_capture(8, 0, 100, 1'b0, 1'b0, 32'h100, 1'b1);
      do_ack();
      test_capture(4, 3, 0, 1'b1, 1'b0, 32'd1, 1'b1);
      do_ack();
      test_capture(2000, 0, 100, 1'b0, 1'b1, '0, 1'b1);
      do_ack();
      test_capture(0, 0, 100, 1'b0, 1'b1, '0, 1'b1);
      do_ack();
      test_abort();
      test_ack_arm();
      test_trig_held();
      test_random();
      test_rst_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
